// File: rtl/guess_checker.sv
// ---------------------------------------------------------------------------
// guess_checker
//
// Consumer end of the secret-number interface. Latches a two-digit signed BCD
// secret and collects the player's guess one digit at a time. Each submitted
// guess is compared against the secret, and the block reports too low, too
// high or correct. It counts attempts and ends the game on a win or when the
// attempts run out.
//
// Ports:
//   Clock         system clock, rising edge
//   Resetn        asynchronous active-low reset
//   load_secret   1-cycle pulse: latch secret_* and start a new game
//   secret_hi/lo  secret tens/units digit (BCD); secret_neg = negative sign
//   digit         guess digit (BCD), qualified by 1-cycle digit_valid pulse
//   sign_in       guess sign, sampled together with submit
//   submit        1-cycle pulse: evaluate the current guess
//   result        00 none, 01 too low, 10 too high, 11 correct
//   result_valid  1-cycle pulse when result updates
//   attempts      guesses submitted this game (saturates at MAX_ATTEMPTS)
//   game_over     high from game end until the next load_secret
//   win           high with game_over when the final guess was correct
//   state         current FSM state, exported for the display
// ---------------------------------------------------------------------------
module guess_checker #(
    parameter int unsigned MAX_ATTEMPTS = 7
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       load_secret,
    input  logic [3:0] secret_hi,
    input  logic [3:0] secret_lo,
    input  logic       secret_neg,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       sign_in,
    input  logic       submit,
    output logic [1:0] result,
    output logic       result_valid,
    output logic [3:0] attempts,
    output logic       game_over,
    output logic       win,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ENTER_HI = 3'd1;
    localparam logic [2:0] ST_ENTER_LO = 3'd2;
    localparam logic [2:0] ST_READY    = 3'd3;
    localparam logic [2:0] ST_COMPARE  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_LOW   = 2'b01;
    localparam logic [1:0] RES_HIGH  = 2'b10;
    localparam logic [1:0] RES_EQUAL = 2'b11;

    localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);

    // Two BCD digits plus sign to 8-bit two's complement (-99..+99).
    // Negating a zero magnitude yields zero, so -0 and +0 compare equal.
    function automatic logic signed [7:0] bcd_to_signed(
        input logic [3:0] hi,
        input logic [3:0] lo,
        input logic       neg
    );
        logic [7:0] mag;
        mag = (8'(hi) * 8'd10) + 8'(lo);
        bcd_to_signed = neg ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic [1:0] compare_guess(
        input logic signed [7:0] guess_v,
        input logic signed [7:0] secret_v
    );
        if (guess_v < secret_v) begin
            compare_guess = RES_LOW;
        end else if (guess_v > secret_v) begin
            compare_guess = RES_HIGH;
        end else begin
            compare_guess = RES_EQUAL;
        end
    endfunction

    logic [2:0] state_q, state_d;
    logic [3:0] secret_hi_q, secret_hi_d;
    logic [3:0] secret_lo_q, secret_lo_d;
    logic       secret_neg_q, secret_neg_d;
    logic [3:0] guess_hi_q, guess_hi_d;
    logic [3:0] guess_lo_q, guess_lo_d;
    logic       guess_neg_q, guess_neg_d;
    logic [1:0] result_q, result_d;
    logic       result_valid_q, result_valid_d;
    logic [3:0] attempts_q, attempts_d;
    logic       game_over_q, game_over_d;
    logic       win_q, win_d;

    logic             digit_ok;
    logic signed [7:0] guess_val;
    logic signed [7:0] secret_val;
    logic [1:0]       cmp_res;

    assign digit_ok   = digit_valid && (digit <= 4'd9);
    assign guess_val  = bcd_to_signed(guess_hi_q, guess_lo_q, guess_neg_q);
    assign secret_val = bcd_to_signed(secret_hi_q, secret_lo_q, secret_neg_q);
    assign cmp_res    = compare_guess(guess_val, secret_val);

    always_comb begin
        state_d        = state_q;
        secret_hi_d    = secret_hi_q;
        secret_lo_d    = secret_lo_q;
        secret_neg_d   = secret_neg_q;
        guess_hi_d     = guess_hi_q;
        guess_lo_d     = guess_lo_q;
        guess_neg_d    = guess_neg_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        attempts_d     = attempts_q;
        game_over_d    = game_over_q;
        win_d          = win_q;

        // load_secret overrides whatever the FSM is doing, including DONE.
        if (load_secret) begin
            secret_hi_d  = secret_hi;
            secret_lo_d  = secret_lo;
            secret_neg_d = secret_neg;
            attempts_d   = 4'd0;
            game_over_d  = 1'b0;
            win_d        = 1'b0;
            result_d     = RES_NONE;
            state_d      = ST_ENTER_HI;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ENTER_HI: begin
                    if (digit_ok) begin
                        guess_hi_d = digit;
                        state_d    = ST_ENTER_LO;
                    end
                end
                ST_ENTER_LO: begin
                    // A submit arriving with the last digit is dropped.
                    if (digit_ok) begin
                        guess_lo_d = digit;
                        state_d    = ST_READY;
                    end
                end
                ST_READY: begin
                    // submit beats a simultaneous digit; a lone digit
                    // restarts entry as the new tens digit.
                    if (submit) begin
                        guess_neg_d = sign_in;
                        if (attempts_q < MAX_A) begin
                            attempts_d = attempts_q + 4'd1;
                        end
                        state_d = ST_COMPARE;
                    end else if (digit_ok) begin
                        guess_hi_d = digit;
                        state_d    = ST_ENTER_LO;
                    end
                end
                ST_COMPARE: begin
                    result_d       = cmp_res;
                    result_valid_d = 1'b1;
                    if (cmp_res == RES_EQUAL) begin
                        win_d       = 1'b1;
                        game_over_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (attempts_q == MAX_A) begin
                        game_over_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_ENTER_HI;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q        <= ST_IDLE;
            secret_hi_q    <= 4'd0;
            secret_lo_q    <= 4'd0;
            secret_neg_q   <= 1'b0;
            guess_hi_q     <= 4'd0;
            guess_lo_q     <= 4'd0;
            guess_neg_q    <= 1'b0;
            result_q       <= RES_NONE;
            result_valid_q <= 1'b0;
            attempts_q     <= 4'd0;
            game_over_q    <= 1'b0;
            win_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            secret_hi_q    <= secret_hi_d;
            secret_lo_q    <= secret_lo_d;
            secret_neg_q   <= secret_neg_d;
            guess_hi_q     <= guess_hi_d;
            guess_lo_q     <= guess_lo_d;
            guess_neg_q    <= guess_neg_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            attempts_q     <= attempts_d;
            game_over_q    <= game_over_d;
            win_q          <= win_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign attempts     = attempts_q;
    assign game_over    = game_over_q;
    assign win          = win_q;
    assign state        = state_q;

endmodule

// File: tb/tb_guess_checker.sv
// Bench for guess_checker: two instances (MAX_ATTEMPTS 7 and 2) share one
// input stream and are checked against a game-rule reference model.
module tb_guess_checker;

    logic       Clock;
    logic       Resetn;
    logic       load_secret;
    logic [3:0] secret_hi;
    logic [3:0] secret_lo;
    logic       secret_neg;
    logic [3:0] digit;
    logic       digit_valid;
    logic       sign_in;
    logic       submit;

    logic [1:0] res0, res1;
    logic       rv0, rv1;
    logic [3:0] att0, att1;
    logic       go0, go1;
    logic       win0, win1;
    logic [2:0] st0, st1;

    int vectors;
    int miscompares;

    guess_checker #(.MAX_ATTEMPTS(7)) dut (
        .Clock(Clock), .Resetn(Resetn), .load_secret(load_secret),
        .secret_hi(secret_hi), .secret_lo(secret_lo), .secret_neg(secret_neg),
        .digit(digit), .digit_valid(digit_valid), .sign_in(sign_in),
        .submit(submit), .result(res0), .result_valid(rv0), .attempts(att0),
        .game_over(go0), .win(win0), .state(st0)
    );

    guess_checker #(.MAX_ATTEMPTS(2)) dut2 (
        .Clock(Clock), .Resetn(Resetn), .load_secret(load_secret),
        .secret_hi(secret_hi), .secret_lo(secret_lo), .secret_neg(secret_neg),
        .digit(digit), .digit_valid(digit_valid), .sign_in(sign_in),
        .submit(submit), .result(res1), .result_valid(rv1), .attempts(att1),
        .game_over(go1), .win(win1), .state(st1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: the game expressed with integers and the state codes
    // the display contract defines.
    typedef struct {
        int st;
        int secret_val;
        int ghi;
        int glo;
        int gsign;
        int res;
        int rv;
        int att;
        int go;
        int w;
    } model_t;

    model_t m[2];
    int     max_att[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k].st = 0; m[k].secret_val = 0; m[k].ghi = 0; m[k].glo = 0;
            m[k].gsign = 0; m[k].res = 0; m[k].rv = 0; m[k].att = 0;
            m[k].go = 0; m[k].w = 0;
        end
    endtask

    task automatic model_step(int k);
        int g;
        int d;
        bit dok;
        d   = int'(digit);
        dok = digit_valid && (d <= 9);
        m[k].rv = 0;
        if (load_secret) begin
            m[k].secret_val = (int'(secret_hi) * 10 + int'(secret_lo)) * (secret_neg ? -1 : 1);
            m[k].att = 0; m[k].go = 0; m[k].w = 0; m[k].res = 0; m[k].st = 1;
        end else begin
            case (m[k].st)
                1: if (dok) begin m[k].ghi = d; m[k].st = 2; end
                2: if (dok) begin m[k].glo = d; m[k].st = 3; end
                3: begin
                    if (submit) begin
                        m[k].gsign = int'(sign_in);
                        if (m[k].att < max_att[k]) m[k].att = m[k].att + 1;
                        m[k].st = 4;
                    end else if (dok) begin
                        m[k].ghi = d; m[k].st = 2;
                    end
                end
                4: begin
                    g = (m[k].ghi * 10 + m[k].glo) * (m[k].gsign != 0 ? -1 : 1);
                    m[k].rv = 1;
                    if (g < m[k].secret_val)      m[k].res = 1;
                    else if (g > m[k].secret_val) m[k].res = 2;
                    else                          m[k].res = 3;
                    if (m[k].res == 3) begin
                        m[k].w = 1; m[k].go = 1; m[k].st = 5;
                    end else if (m[k].att == max_att[k]) begin
                        m[k].go = 1; m[k].st = 5;
                    end else begin
                        m[k].st = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("result0",    32'(res0), 32'(m[0].res));
        chk("rvalid0",    32'(rv0),  32'(m[0].rv));
        chk("attempts0",  32'(att0), 32'(m[0].att));
        chk("game_over0", 32'(go0),  32'(m[0].go));
        chk("win0",       32'(win0), 32'(m[0].w));
        chk("state0",     32'(st0),  32'(m[0].st));
        chk("result1",    32'(res1), 32'(m[1].res));
        chk("rvalid1",    32'(rv1),  32'(m[1].rv));
        chk("attempts1",  32'(att1), 32'(m[1].att));
        chk("game_over1", 32'(go1),  32'(m[1].go));
        chk("win1",       32'(win1), 32'(m[1].w));
        chk("state1",     32'(st1),  32'(m[1].st));
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge Clock);
        #1;
        check_all();
        load_secret = 1'b0;
        digit_valid = 1'b0;
        submit      = 1'b0;
    endtask

    task automatic reset_now();
        Resetn = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic load(int hi, int lo, bit neg);
        secret_hi = 4'(hi); secret_lo = 4'(lo); secret_neg = neg;
        load_secret = 1'b1;
        tick();
    endtask

    task automatic enter(int d);
        digit = 4'(d); digit_valid = 1'b1;
        tick();
    endtask

    task automatic do_submit(bit s);
        sign_in = s; submit = 1'b1;
        tick();
    endtask

    // Full guess: two digits, submit, then the compare cycle.
    task automatic guess(int hi, int lo, bit s);
        enter(hi);
        enter(lo);
        do_submit(s);
        tick();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        max_att[0] = 7; max_att[1] = 2;
        model_reset();
        Resetn = 1'b1; load_secret = 1'b0; secret_hi = 4'd0; secret_lo = 4'd0;
        secret_neg = 1'b0; digit = 4'd0; digit_valid = 1'b0; sign_in = 1'b0;
        submit = 1'b0;
        #2;
        reset_now();
        chk("reset_state", 32'(st0), 32'd0);
        chk("reset_attempts", 32'(att0), 32'd0);

        // Correct first guess +42.
        load(4, 2, 1'b0);
        guess(4, 2, 1'b0);
        chk("tp1_result", 32'(res0), 32'd3);
        chk("tp1_rvalid", 32'(rv0), 32'd1);
        chk("tp1_win", 32'(win0), 32'd1);
        chk("tp1_game_over", 32'(go0), 32'd1);
        chk("tp1_attempts", 32'(att0), 32'd1);
        chk("tp1_state", 32'(st0), 32'd5);
        tick();
        chk("tp1_rvalid_drop", 32'(rv0), 32'd0);
        chk("tp1_result_hold", 32'(res0), 32'd3);

        // Secret -35: high, low, then correct.
        load(3, 5, 1'b1);
        guess(1, 0, 1'b0);
        chk("tp2_high", 32'(res0), 32'd2);
        guess(5, 0, 1'b1);
        chk("tp2_low", 32'(res0), 32'd1);
        chk("tp2_max2_over", 32'(go1), 32'd1);
        guess(3, 5, 1'b1);
        chk("tp2_equal", 32'(res0), 32'd3);
        chk("tp2_attempts", 32'(att0), 32'd3);
        chk("tp2_win", 32'(win0), 32'd1);

        // Secret 7 with the MAX_ATTEMPTS=2 instance running out.
        load(0, 7, 1'b0);
        guess(0, 1, 1'b0);
        chk("tp3_first_low", 32'(res1), 32'd1);
        chk("tp3_first_not_over", 32'(go1), 32'd0);
        guess(0, 2, 1'b0);
        chk("tp3_over", 32'(go1), 32'd1);
        chk("tp3_win", 32'(win1), 32'd0);
        chk("tp3_attempts", 32'(att1), 32'd2);
        guess(0, 7, 1'b0);
        chk("tp3_done_result", 32'(res1), 32'd1);
        chk("tp3_done_attempts", 32'(att1), 32'd2);
        chk("tp3_done_state", 32'(st1), 32'd5);

        // Negative zero secret equals +00 guess.
        load(0, 0, 1'b1);
        guess(0, 0, 1'b0);
        chk("tp4_negzero", 32'(res0), 32'd3);

        // Entry corner cases.
        load(5, 5, 1'b0);
        enter(12);
        chk("tp5_bad_digit", 32'(st0), 32'd1);
        enter(3);
        do_submit(1'b0);
        chk("tp5_submit_ignored_state", 32'(st0), 32'd2);
        chk("tp5_submit_ignored_att", 32'(att0), 32'd0);
        digit = 4'd4; digit_valid = 1'b1; submit = 1'b1;
        tick();
        chk("tp5_both_state", 32'(st0), 32'd3);
        chk("tp5_both_att", 32'(att0), 32'd0);

        // Asynchronous reset from READY.
        reset_now();
        chk("tp6_reset_state", 32'(st0), 32'd0);
        chk("tp6_reset_result", 32'(res0), 32'd0);

        // New game from DONE.
        load(1, 1, 1'b0);
        guess(1, 1, 1'b0);
        chk("tp6_done", 32'(st0), 32'd5);
        load(2, 2, 1'b0);
        chk("tp6_reload_att", 32'(att0), 32'd0);
        chk("tp6_reload_over", 32'(go0), 32'd0);
        chk("tp6_reload_state", 32'(st0), 32'd1);

        // Randomized play against the model.
        for (int i = 0; i < 600; i++) begin
            load_secret = ($urandom_range(0, 24) == 0);
            secret_hi   = 4'($urandom_range(0, 9));
            secret_lo   = 4'($urandom_range(0, 9));
            secret_neg  = 1'($urandom_range(0, 1));
            digit       = 4'($urandom_range(0, 11));
            digit_valid = ($urandom_range(0, 1) == 1);
            sign_in     = 1'($urandom_range(0, 1));
            submit      = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
